seq_alu: RTL

Parametrised, registered, multi-cycle ALU. Successor to the combinational 8-bit ALU: WIDTH-generic operands, valid/ready handshakes on input and output, an iterative shift-add multiplier returning the full double-width product, a bidirectional barrel shift, and a status-flag vector. Sits between the operand register file and the writeback stage of the datapath, one operation in flight at a time.

---
 rtl/seq_alu_pkg.sv | 24 ++
 rtl/seq_alu_mul.sv | 46 ++++
 rtl/seq_alu.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states and flag bit positions.
package seq_alu_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_MUL   = 3'b010;
    localparam logic [2:0] OP_SHIFT = 3'b011;
    localparam logic [2:0] OP_OR    = 3'b100;
    localparam logic [2:0] OP_NOT   = 3'b101;
    localparam logic [2:0] OP_XOR   = 3'b110;
    localparam logic [2:0] OP_NAND  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int FLG_C = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_N = 1;
    localparam int FLG_V = 0;

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles per start.
module seq_alu_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    // The last addition is exposed combinationally so the owner can register
    // the full product on the same edge the final iteration completes.
    assign acc_nxt = mplier[0] ? acc + mcand : acc;
    assign done    = (cnt == CW'(1));
    assign product = acc_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= CW'(WIDTH);
        end else if (cnt != '0) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Registered multi-cycle ALU with valid/ready on both sides; one operation in flight.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] res_hi,
    output logic [3:0]       flags
);
    localparam int SHW = $clog2(WIDTH);

    state_t state;
    state_t state_nxt;

    logic               accept;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] shl;
    logic [2*WIDTH-1:0] shr;
    logic [SHW-1:0]     amt;
    logic               amt_big;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;
    logic [3:0]         alu_flags;
    logic [3:0]         mul_flags;

    assign accept    = in_valid && (state == ST_IDLE);
    assign mul_start = accept && (op == OP_MUL);

    seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_prod)
    );

    // Shifts run through a double-width window so the bit that falls off
    // the end is still visible as the carry.
    assign amt     = b[SHW-1:0];
    assign amt_big = 32'(amt) >= WIDTH;
    assign sum     = {1'b0, a} + {1'b0, b};
    assign diff    = {1'b0, a} - {1'b0, b};
    assign shl     = {{WIDTH{1'b0}}, a} << amt;
    assign shr     = {a, {WIDTH{1'b0}}} >> amt;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SHIFT: begin
                if (!amt_big) begin
                    if (b[WIDTH-1]) begin
                        alu_res = shr[2*WIDTH-1:WIDTH];
                        alu_c   = shr[WIDTH-1];
                    end else begin
                        alu_res = shl[WIDTH-1:0];
                        alu_c   = shl[WIDTH];
                    end
                end
            end
            OP_OR:   alu_res = a | b;
            OP_NOT:  alu_res = ~a;
            OP_XOR:  alu_res = a ^ b;
            OP_NAND: alu_res = ~(a & b);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        alu_flags        = '0;
        alu_flags[FLG_C] = alu_c;
        alu_flags[FLG_Z] = (alu_res == '0);
        alu_flags[FLG_N] = alu_res[WIDTH-1];
        alu_flags[FLG_V] = alu_v;

        mul_flags        = '0;
        mul_flags[FLG_Z] = (mul_prod == '0);
        mul_flags[FLG_N] = mul_prod[2*WIDTH-1];
        mul_flags[FLG_V] = (mul_prod[2*WIDTH-1:WIDTH] != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = (op == OP_MUL) ? ST_MUL : ST_DONE;
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            res       <= '0;
            res_hi    <= '0;
            flags     <= '0;
        end else begin
            out_valid <= (state_nxt == ST_DONE);
            if (accept && (op != OP_MUL)) begin
                res    <= alu_res;
                res_hi <= '0;
                flags  <= alu_flags;
            end else if ((state == ST_MUL) && mul_done) begin
                res    <= mul_prod[WIDTH-1:0];
                res_hi <= mul_prod[2*WIDTH-1:WIDTH];
                flags  <= mul_flags;
            end
        end
    end

endmodule
